led_pattern_sequencer: RTL and testbench
========================================

// Module: led_pattern_sequencer
// PURPOSE
//  Sequences the LED outputs of the LED connector peripheral from its AXI4-Lite config registers.
//  Produces static, rotating, bouncing or blinking patterns at a programmable step period,
//  either continuously or as a one-shot of N steps. Sits between the AXI4-Lite slave register
//  file and the board LED pins.
// PARAMETERS
//  LED_WIDTH   8   number of LED outputs
//  CNT_WIDTH   32  width of period counter / cfg_period
//  STEP_WIDTH  8   width of step counter / cfg_steps
// PORTS
//  ACLK          in   1           system clock; all logic rising-edge
//  ARESETN       in   1           asynchronous active-low reset
//  ctrl_en       in   1           level enable; 0 = sequencer off
//  ctrl_mode     in   2           00 static, 01 rotate, 10 bounce, 11 blink
//  ctrl_dir      in   1           initial direction: 0 left (toward MSB), 1 right
//  ctrl_oneshot  in   1           1 = stop after cfg_steps steps
//  cfg_pattern   in   LED_WIDTH   start pattern
//  cfg_period    in   CNT_WIDTH   clocks per step; 0 treated as 1
//  cfg_steps     in   STEP_WIDTH  one-shot step count; 0 treated as 1
//  cfg_update    in   1           1-cycle pulse from register file on any cfg/ctrl write
//  led_out       out  LED_WIDTH   LED drive
//  busy          out  1           1 while in RUN
//  done          out  1           1-cycle pulse at one-shot completion
//  step_count    out  STEP_WIDTH  steps taken since (re)start
// BEHAVIOUR
//  - Reset (ARESETN=0, async): state IDLE, led_out=0, busy=0, done=0, step_count=0, tick=0, dir=0.
//  - States: IDLE, RUN, DONE. Registered outputs; no combinational input->output paths.
//  - IDLE: led_out=0. ctrl_en=1 sampled on edge k -> at edge k+1: RUN, led_out=cfg_pattern,
//    tick=0, step_count=0, dir=ctrl_dir, busy=1.
//  - RUN: tick increments each clock. Step event when tick >= max(cfg_period,1)-1 (live compare,
//    so shrinking cfg_period steps on the next cycle); tick<=0 on step event.
//    First step lands max(cfg_period,1) clocks after entering RUN.
//  - Step actions: static: led_out unchanged; rotate: rotate 1 bit in dir;
//    bounce: rotate 1 bit in dir, then if new value has bit at travel end set
//    (MSB for left, LSB for right) flip dir; blink: led_out <= (led_out==0) ? cfg_pattern : 0.
//  - step_count +1 per step event, wraps mod 2^STEP_WIDTH in continuous mode.
//  - One-shot: on step event where step_count+1 == max(cfg_steps,1): -> DONE, done=1 one cycle,
//    busy=0, led_out holds the stepped value, step_count holds final value.
//  - DONE: hold outputs. ctrl_en=0 -> IDLE (led_out=0). cfg_update with ctrl_en=1 -> restart
//    RUN exactly as from IDLE.
//  - ctrl_en=0 in RUN -> IDLE next edge, led_out=0, busy=0, no done pulse.
//  - cfg_update in RUN (ctrl_en=1): restart (pattern reload, tick=0, step_count=0, dir=ctrl_dir);
//    has priority over a coincident step event and over one-shot completion.
//  - ctrl_en=0 has priority over cfg_update in every state.
//  - Pattern all-0 or all-1: rotate/bounce produce same value; bounce never sees a single
//    travel-end transition issue -- dir flips per rule above, output unchanged. Legal, no error.
//  - ctrl_mode/ctrl_dir changes without cfg_update: mode used live at next step; dir not reloaded.
//  - Reset asserted mid-RUN: outputs to reset values immediately; no done pulse.
// TESTING
//  1 ARESETN=0 200ns, cfg_pattern=0xFF, ctrl_en=1 -> led_out=0, busy=0 during reset; 0xFF one edge after release.
//  2 rotate, dir=0, pattern 0x01, period 4, continuous -> 0x01,0x02,..,0x80,0x01 every 4 clk; step_count 1..8.
//  3 rotate, dir=1, pattern 0x80, period 1, oneshot, steps 3 -> 0x40,0x20,0x10; done 1 cycle; busy=0; led_out holds 0x10.
//  4 bounce, dir=0, pattern 0x03, period 2 -> 0x06,0x0C,0x18,0x30,0x60,0xC0,0x60,0x30 (reverses at MSB).
//  5 blink, pattern 0xA5, period 0 -> led_out alternates 0xA5/0x00 every clock after first.
//  6 cfg_update coincident with step in RUN -> led_out=cfg_pattern, step_count=0; then ctrl_en=0 -> led_out=0 next edge, no done.

Source files
------------

// File: rtl/led_pattern_sequencer.sv
// Purpose: drives the board LEDs with static, rotating, bouncing or blinking patterns
//          from the peripheral's config registers, continuously or as a one-shot of N steps.
// Latency/flow: all outputs registered; enable seen on edge k takes effect at edge k+1; no backpressure.
// Ports: ACLK/ARESETN clock and async active-low reset; ctrl_* mode/enable controls;
//        cfg_* pattern, step period and one-shot step count; cfg_update reload pulse;
//        led_out LED drive, busy while running, done one-shot completion pulse,
//        step_count steps since the last (re)start.
module led_pattern_sequencer #(
    parameter int LED_WIDTH  = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  ctrl_en,
    input  logic [1:0]            ctrl_mode,
    input  logic                  ctrl_dir,
    input  logic                  ctrl_oneshot,
    input  logic [LED_WIDTH-1:0]  cfg_pattern,
    input  logic [CNT_WIDTH-1:0]  cfg_period,
    input  logic [STEP_WIDTH-1:0] cfg_steps,
    input  logic                  cfg_update,
    output logic [LED_WIDTH-1:0]  led_out,
    output logic                  busy,
    output logic                  done,
    output logic [STEP_WIDTH-1:0] step_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_STATIC = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [STEP_WIDTH-1:0] STEP_ONE = STEP_WIDTH'(1);

    state_t                state_q, state_d;
    logic [LED_WIDTH-1:0]  led_d;
    logic                  busy_d;
    logic                  done_d;
    logic [STEP_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0]  tick_q, tick_d;
    logic                  dir_q, dir_d;   // 0 = toward MSB, 1 = toward LSB

    logic [CNT_WIDTH-1:0]  period_eff;
    logic [STEP_WIDTH-1:0] steps_eff;
    logic [STEP_WIDTH-1:0] cnt_inc;
    logic                  step_ev;
    logic [LED_WIDTH-1:0]  rot_l, rot_r;
    logic [LED_WIDTH-1:0]  step_led;
    logic                  step_dir;
    logic                  restart;

    // A programmed zero means "every clock" / "one step".
    assign period_eff = (cfg_period == '0) ? CNT_ONE : cfg_period;
    assign steps_eff  = (cfg_steps == '0) ? STEP_ONE : cfg_steps;
    assign cnt_inc    = step_count + STEP_ONE;
    // Live compare so a shrinking period takes effect on the very next clock.
    assign step_ev    = (tick_q >= period_eff - CNT_ONE);

    assign rot_l = {led_out[LED_WIDTH-2:0], led_out[LED_WIDTH-1]};
    assign rot_r = {led_out[0], led_out[LED_WIDTH-1:1]};

    // Value and direction that a step event would produce, using the live mode.
    always_comb begin
        step_led = led_out;
        step_dir = dir_q;
        case (ctrl_mode)
            MODE_STATIC: step_led = led_out;
            MODE_ROTATE: step_led = dir_q ? rot_r : rot_l;
            MODE_BOUNCE: begin
                step_led = dir_q ? rot_r : rot_l;
                // Reverse once the rotated value occupies the end it is travelling toward.
                if (!dir_q && step_led[LED_WIDTH-1]) begin
                    step_dir = 1'b1;
                end else if (dir_q && step_led[0]) begin
                    step_dir = 1'b0;
                end
            end
            MODE_BLINK:  step_led = (led_out == '0) ? cfg_pattern : '0;
            default:     step_led = led_out;
        endcase
    end

    always_comb begin
        state_d = state_q;
        led_d   = led_out;
        busy_d  = busy;
        done_d  = 1'b0;
        cnt_d   = step_count;
        tick_d  = tick_q;
        dir_d   = dir_q;
        restart = 1'b0;

        case (state_q)
            S_IDLE: begin
                led_d  = '0;
                busy_d = 1'b0;
                if (ctrl_en) begin
                    restart = 1'b1;
                end
            end
            S_RUN: begin
                if (!ctrl_en) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                    busy_d  = 1'b0;
                end else if (cfg_update) begin
                    // Reload beats a coincident step and one-shot completion.
                    restart = 1'b1;
                end else if (step_ev) begin
                    tick_d = '0;
                    led_d  = step_led;
                    dir_d  = step_dir;
                    cnt_d  = cnt_inc;
                    if (ctrl_oneshot && (cnt_inc == steps_eff)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    tick_d = tick_q + CNT_ONE;
                end
            end
            S_DONE: begin
                if (!ctrl_en) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                    busy_d  = 1'b0;
                end else if (cfg_update) begin
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = '0;
                busy_d  = 1'b0;
            end
        endcase

        if (restart) begin
            state_d = S_RUN;
            led_d   = cfg_pattern;
            tick_d  = '0;
            cnt_d   = '0;
            dir_d   = ctrl_dir;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q    <= S_IDLE;
            led_out    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            step_count <= '0;
            tick_q     <= '0;
            dir_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_out    <= led_d;
            busy       <= busy_d;
            done       <= done_d;
            step_count <= cnt_d;
            tick_q     <= tick_d;
            dir_q      <= dir_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Purpose: self-checking bench for led_pattern_sequencer (directed table, hand sequences, random vs model).
// Latency: outputs sampled 1 time unit after each rising edge; inputs driven at the same point.
// Backpressure: none; every wait is a fixed cycle count.
module tb_led_pattern_sequencer;

    logic        ACLK;
    logic        ARESETN;
    logic        ctrl_en;
    logic [1:0]  ctrl_mode;
    logic        ctrl_dir;
    logic        ctrl_oneshot;
    logic [7:0]  cfg_pattern;
    logic [31:0] cfg_period;
    logic [7:0]  cfg_steps;
    logic        cfg_update;
    logic [7:0]  led_out;
    logic        busy;
    logic        done;
    logic [7:0]  step_count;

    int total;
    int bad;

    led_pattern_sequencer #(
        .LED_WIDTH (8),
        .CNT_WIDTH (32),
        .STEP_WIDTH(8)
    ) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .ctrl_en     (ctrl_en),
        .ctrl_mode   (ctrl_mode),
        .ctrl_dir    (ctrl_dir),
        .ctrl_oneshot(ctrl_oneshot),
        .cfg_pattern (cfg_pattern),
        .cfg_period  (cfg_period),
        .cfg_steps   (cfg_steps),
        .cfg_update  (cfg_update),
        .led_out     (led_out),
        .busy        (busy),
        .done        (done),
        .step_count  (step_count)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0]  mode;
        logic        dir;
        logic        oneshot;
        logic [7:0]  pattern;
        logic [31:0] period;
        logic [7:0]  steps;
        int          ncyc;
        logic [7:0]  exp_led;
        logic [7:0]  exp_cnt;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[12];

    // Reference model state: whether running, whether a one-shot finished,
    // the LED value, steps taken, clocks since last step, travel direction.
    bit m_active, m_finished, m_left, m_done;
    int m_led, m_cnt, m_clocks;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick_clk();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic dir, input logic os,
                           input logic [7:0] pat, input logic [31:0] per, input logic [7:0] st);
        ctrl_mode    = mode;
        ctrl_dir     = dir;
        ctrl_oneshot = os;
        cfg_pattern  = pat;
        cfg_period   = per;
        cfg_steps    = st;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        ctrl_en    = 1'b0;
        cfg_update = 1'b0;
        tick_clk();
        tick_clk();
        set_cfg(v.mode, v.dir, v.oneshot, v.pattern, v.period, v.steps);
        ctrl_en = 1'b1;
        tick_clk();
        repeat (v.ncyc) tick_clk();
        check($sformatf("vec%0d_led", idx), led_out, v.exp_led);
        check($sformatf("vec%0d_cnt", idx), step_count, v.exp_cnt);
        check($sformatf("vec%0d_busy", idx), busy, v.exp_busy);
    endtask

    // One clock of the behavioural model using the inputs present before the edge.
    task automatic model_edge();
        int per, lim;
        m_done = 1'b0;
        if (!ctrl_en) begin
            m_active   = 1'b0;
            m_finished = 1'b0;
            m_led      = 0;
        end else if ((!m_active && !m_finished) || cfg_update) begin
            m_active   = 1'b1;
            m_finished = 1'b0;
            m_led      = cfg_pattern;
            m_cnt      = 0;
            m_clocks   = 0;
            m_left     = !ctrl_dir;
        end else if (m_active) begin
            per = (cfg_period == 0) ? 1 : int'(cfg_period);
            m_clocks++;
            if (m_clocks >= per) begin
                m_clocks = 0;
                case (ctrl_mode)
                    2'd1, 2'd2: begin
                        if (m_left) m_led = (m_led * 2) % 256 + m_led / 128;
                        else        m_led = m_led / 2 + (m_led % 2) * 128;
                        if (ctrl_mode == 2'd2) begin
                            if (m_left && m_led >= 128)          m_left = 1'b0;
                            else if (!m_left && (m_led % 2) == 1) m_left = 1'b1;
                        end
                    end
                    2'd3:    m_led = (m_led == 0) ? int'(cfg_pattern) : 0;
                    default: m_led = m_led;
                endcase
                m_cnt = (m_cnt + 1) % 256;
                lim = (cfg_steps == 0) ? 1 : int'(cfg_steps);
                if (ctrl_oneshot && m_cnt == lim) begin
                    m_active   = 1'b0;
                    m_finished = 1'b1;
                    m_done     = 1'b1;
                end
            end
        end
    endtask

    logic [7:0] seq3 [3];

    initial begin
        total = 0;
        bad   = 0;

        //                mode  dir   os    pat    period  steps ncyc led    cnt    busy
        vecs[0]  = '{2'd1, 1'b0, 1'b0, 8'h01, 32'd4, 8'd0, 12,  8'h08, 8'd3, 1'b1};
        vecs[1]  = '{2'd1, 1'b0, 1'b0, 8'h01, 32'd4, 8'd0, 32,  8'h01, 8'd8, 1'b1};
        vecs[2]  = '{2'd1, 1'b1, 1'b1, 8'h80, 32'd1, 8'd3, 3,   8'h10, 8'd3, 1'b0};
        vecs[3]  = '{2'd1, 1'b1, 1'b1, 8'h80, 32'd1, 8'd3, 6,   8'h10, 8'd3, 1'b0};
        vecs[4]  = '{2'd2, 1'b0, 1'b0, 8'h03, 32'd2, 8'd0, 16,  8'h30, 8'd8, 1'b1};
        vecs[5]  = '{2'd3, 1'b0, 1'b0, 8'hA5, 32'd0, 8'd0, 1,   8'h00, 8'd1, 1'b1};
        vecs[6]  = '{2'd3, 1'b0, 1'b0, 8'hA5, 32'd0, 8'd0, 2,   8'hA5, 8'd2, 1'b1};
        vecs[7]  = '{2'd0, 1'b0, 1'b0, 8'h5A, 32'd3, 8'd0, 9,   8'h5A, 8'd3, 1'b1};
        vecs[8]  = '{2'd1, 1'b0, 1'b1, 8'h01, 32'd2, 8'd0, 5,   8'h02, 8'd1, 1'b0};
        vecs[9]  = '{2'd2, 1'b1, 1'b0, 8'h81, 32'd1, 8'd0, 8,   8'h06, 8'd8, 1'b1};
        vecs[10] = '{2'd2, 1'b0, 1'b0, 8'hFF, 32'd1, 8'd0, 5,   8'hFF, 8'd5, 1'b1};
        vecs[11] = '{2'd1, 1'b0, 1'b0, 8'h01, 32'd1, 8'd0, 256, 8'h01, 8'd0, 1'b1};

        // Reset held with enable already high.
        ARESETN    = 1'b0;
        ctrl_en    = 1'b1;
        cfg_update = 1'b0;
        set_cfg(2'd0, 1'b0, 1'b0, 8'hFF, 32'd4, 8'd0);
        #200;
        check("rst_led", led_out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cnt", step_count, 8'd0);
        ARESETN = 1'b1;
        tick_clk();
        check("post_rst_led", led_out, 8'hFF);
        check("post_rst_busy", busy, 1'b1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // One-shot rotate right: done pulse width, hold in DONE, restart from DONE.
        seq3[0] = 8'h40; seq3[1] = 8'h20; seq3[2] = 8'h10;
        ctrl_en = 1'b0;
        tick_clk();
        set_cfg(2'd1, 1'b1, 1'b1, 8'h80, 32'd1, 8'd3);
        ctrl_en = 1'b1;
        tick_clk();
        check("os_start_led", led_out, 8'h80);
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            check($sformatf("os_step%0d_led", i), led_out, seq3[i]);
            check($sformatf("os_step%0d_done", i), done, (i == 2) ? 1'b1 : 1'b0);
        end
        tick_clk();
        check("os_hold_done", done, 1'b0);
        check("os_hold_led", led_out, 8'h10);
        check("os_hold_busy", busy, 1'b0);
        check("os_hold_cnt", step_count, 8'd3);
        cfg_update = 1'b1;
        tick_clk();
        cfg_update = 1'b0;
        check("os_restart_led", led_out, 8'h80);
        check("os_restart_busy", busy, 1'b1);
        check("os_restart_cnt", step_count, 8'd0);

        // Blink at period 0 toggles every clock.
        ctrl_en = 1'b0;
        tick_clk();
        set_cfg(2'd3, 1'b0, 1'b0, 8'hA5, 32'd0, 8'd0);
        ctrl_en = 1'b1;
        tick_clk();
        for (int i = 0; i < 6; i++) begin
            tick_clk();
            check($sformatf("blink%0d", i), led_out, (i % 2 == 0) ? 8'h00 : 8'hA5);
        end

        // Reload coinciding with a step event, then disable.
        ctrl_en = 1'b0;
        tick_clk();
        set_cfg(2'd1, 1'b0, 1'b0, 8'h01, 32'd2, 8'd0);
        ctrl_en = 1'b1;
        tick_clk();
        tick_clk();
        check("upd_pre_led", led_out, 8'h01);
        cfg_update  = 1'b1;
        cfg_pattern = 8'h3C;
        tick_clk();
        cfg_update = 1'b0;
        check("upd_led", led_out, 8'h3C);
        check("upd_cnt", step_count, 8'd0);
        check("upd_busy", busy, 1'b1);
        ctrl_en = 1'b0;
        tick_clk();
        check("dis_led", led_out, 8'h00);
        check("dis_busy", busy, 1'b0);
        check("dis_done", done, 1'b0);

        // Asynchronous reset in the middle of a run.
        set_cfg(2'd1, 1'b0, 1'b0, 8'h11, 32'd1, 8'd0);
        ctrl_en = 1'b1;
        tick_clk();
        tick_clk();
        tick_clk();
        #2;
        ARESETN = 1'b0;
        #1;
        check("arst_led", led_out, 8'h00);
        check("arst_busy", busy, 1'b0);
        check("arst_cnt", step_count, 8'd0);
        check("arst_done", done, 1'b0);
        ctrl_en = 1'b0;
        #3;
        ARESETN = 1'b1;
        tick_clk();

        // Randomized traffic against the behavioural model.
        m_active   = 1'b0;
        m_finished = 1'b0;
        m_led      = 0;
        m_cnt      = 0;
        m_clocks   = 0;
        m_left     = 1'b1;
        m_done     = 1'b0;
        set_cfg(2'd1, 1'b0, 1'b0, 8'h01, 32'd1, 8'd2);
        for (int i = 0; i < 1500; i++) begin
            ctrl_en    = ($urandom_range(0, 99) < 97);
            cfg_update = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 8) ctrl_mode    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 8) ctrl_dir     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 8) ctrl_oneshot = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 8) cfg_pattern  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 8) cfg_period   = 32'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 8) cfg_steps    = 8'($urandom_range(0, 6));
            @(posedge ACLK);
            model_edge();
            #1;
            check("rnd_led", led_out, m_led);
            check("rnd_busy", busy, m_active);
            check("rnd_done", done, m_done);
            if (m_active || m_finished) check("rnd_cnt", step_count, m_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
